// File: rtl/gpu_pkg.sv
// Shared types and constants for the GPU command path.
package gpu_pkg;

  localparam int OP_W    = 4;
  localparam int PARAM_W = 25;

  localparam logic [OP_W-1:0] OPC_NOP = 4'h0;

  typedef struct packed {
    logic [OP_W-1:0]    opcode;
    logic [PARAM_W-1:0] parameters;
  } gpu_cmd_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } sched_state_t;

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Synchronous command FIFO; push is ignored when full and pop when empty.
module gpu_cmd_fifo
  import gpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   push,
  input  logic                   pop,
  input  gpu_cmd_t               wdata,
  output gpu_cmd_t               rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  gpu_cmd_t             mem_r [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     count_r;
  logic                 push_ok_s;
  logic                 pop_ok_s;

  // Qualify requests against the current occupancy.
  always_comb begin
    push_ok_s = push && !full;
    pop_ok_s  = pop && !empty;
  end

  // Storage, pointers (wrap naturally since DEPTH is a power of two) and count.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == CNT_W'(0));

endmodule

// File: rtl/gpu_cmd_sched.sv
// Buffers decoded GPU commands and issues them one at a time with a
// start/busy handshake, flagging dropped commands and missing acknowledges.
module gpu_cmd_sched
  import gpu_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   cmd_valid_i,
  input  logic [OP_W-1:0]        opcode_i,
  input  logic [PARAM_W-1:0]     parameters_i,
  output logic                   cmd_ready_o,
  output logic                   gpu_start_o,
  output logic [OP_W-1:0]        gpu_opcode_o,
  output logic [PARAM_W-1:0]     gpu_parameters_o,
  input  logic                   gpu_busy_i,
  output logic [$clog2(DEPTH):0] fifo_count_o,
  output logic                   overflow_o,
  output logic                   timeout_o,
  output logic                   idle_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int TO_W  = $clog2(ACK_TIMEOUT);

  sched_state_t        state_r;
  logic [TO_W-1:0]     to_cnt_r;
  logic                start_r;
  logic [OP_W-1:0]     opcode_r;
  logic [PARAM_W-1:0]  params_r;
  logic                overflow_r;
  logic                timeout_r;

  gpu_cmd_t            wr_cmd_s;
  gpu_cmd_t            head_s;
  logic [CNT_W-1:0]    count_s;
  logic                full_s;
  logic                empty_s;
  logic                is_cmd_s;
  logic                push_s;
  logic                drop_s;
  logic                pop_s;

  // NOPs never reach the FIFO; readiness is judged on the pre-edge count only.
  always_comb begin
    wr_cmd_s.opcode     = opcode_i;
    wr_cmd_s.parameters = parameters_i;
    is_cmd_s            = cmd_valid_i && (opcode_i != OPC_NOP);
    push_s              = is_cmd_s && !full_s;
    drop_s              = is_cmd_s && full_s;
    pop_s               = (state_r == IDLE) && !empty_s;
  end

  gpu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (wr_cmd_s),
    .rdata (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Issue FSM with ack timeout counter and sticky error flags.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_r    <= IDLE;
      to_cnt_r   <= TO_W'(0);
      start_r    <= 1'b0;
      opcode_r   <= OP_W'(0);
      params_r   <= PARAM_W'(0);
      overflow_r <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      start_r <= 1'b0;
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            opcode_r <= head_s.opcode;
            params_r <= head_s.parameters;
            start_r  <= 1'b1;
            state_r  <= ISSUE;
          end
        end
        ISSUE: begin
          to_cnt_r <= TO_W'(0);
          state_r  <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // An unacknowledged command is abandoned rather than retried.
          if (gpu_busy_i) begin
            state_r <= WAIT_DONE;
          end else if (to_cnt_r == TO_W'(ACK_TIMEOUT - 1)) begin
            timeout_r <= 1'b1;
            state_r   <= IDLE;
          end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!gpu_busy_i) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o      = !full_s;
  assign gpu_start_o      = start_r;
  assign gpu_opcode_o     = opcode_r;
  assign gpu_parameters_o = params_r;
  assign fifo_count_o     = count_s;
  assign overflow_o       = overflow_r;
  assign timeout_o        = timeout_r;
  assign idle_o           = (state_r == IDLE) && empty_s;

endmodule

// File: tb/tb_gpu_cmd_sched.sv
// Directed self-checking bench for gpu_cmd_sched (DEPTH=4, ACK_TIMEOUT=8).
module tb_gpu_cmd_sched;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        cmd_valid;
  logic [3:0]  opcode;
  logic [24:0] params;
  logic        cmd_ready;
  logic        gpu_start;
  logic [3:0]  gpu_opcode;
  logic [24:0] gpu_params;
  logic        gpu_busy;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        timeout;
  logic        idle;

  int n_cmp = 0;
  int n_err = 0;

  gpu_cmd_sched dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .cmd_valid_i      (cmd_valid),
    .opcode_i         (opcode),
    .parameters_i     (params),
    .cmd_ready_o      (cmd_ready),
    .gpu_start_o      (gpu_start),
    .gpu_opcode_o     (gpu_opcode),
    .gpu_parameters_o (gpu_params),
    .gpu_busy_i       (gpu_busy),
    .fifo_count_o     (fifo_count),
    .overflow_o       (overflow),
    .timeout_o        (timeout),
    .idle_o           (idle)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [3:0] op, input logic [24:0] par);
    cmd_valid = 1'b1;
    opcode    = op;
    params    = par;
    step(1);
    cmd_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_start"},    32'(gpu_start),  32'd0);
    check_eq({pfx, "_opcode"},   32'(gpu_opcode), 32'd0);
    check_eq({pfx, "_params"},   32'(gpu_params), 32'd0);
    check_eq({pfx, "_count"},    32'(fifo_count), 32'd0);
    check_eq({pfx, "_overflow"}, 32'(overflow),   32'd0);
    check_eq({pfx, "_timeout"},  32'(timeout),    32'd0);
    check_eq({pfx, "_ready"},    32'(cmd_ready),  32'd1);
    check_eq({pfx, "_idle"},     32'(idle),       32'd1);
  endtask

  // Wait (bounded) for the next start pulse, check it, then ack and complete it.
  task automatic serve(input logic [3:0] exp_op, input logic [24:0] exp_par);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1);
      if (gpu_start) found = 1'b1;
    end
    check_eq("serve_start_seen", 32'(found), 32'd1);
    check_eq("serve_opcode", 32'(gpu_opcode), 32'(exp_op));
    check_eq("serve_params", 32'(gpu_params), 32'(exp_par));
    gpu_busy = 1'b1;
    step(2);
    gpu_busy = 1'b0;
  endtask

  task automatic count_starts(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (gpu_start) c++;
    end
  endtask

  initial begin
    int c;
    n_rst     = 1'b0;
    cmd_valid = 1'b0;
    opcode    = 4'h0;
    params    = 25'h0;
    gpu_busy  = 1'b0;
    step(2);
    check_reset_vals("rst");
    n_rst = 1'b1;

    // Single issue: start between E1 and E2, ack, complete.
    push(4'h9, 25'h1C71FCF);
    check_eq("t1_count_e0", 32'(fifo_count), 32'd1);
    check_eq("t1_start_e0", 32'(gpu_start), 32'd0);
    step(1);
    check_eq("t1_start_e1", 32'(gpu_start), 32'd1);
    check_eq("t1_opcode", 32'(gpu_opcode), 32'h9);
    check_eq("t1_params", 32'(gpu_params), 32'h1C71FCF);
    check_eq("t1_count_e1", 32'(fifo_count), 32'd0);
    gpu_busy = 1'b1;
    step(1);
    check_eq("t1_start_e2", 32'(gpu_start), 32'd0);
    step(4);
    gpu_busy = 1'b0;
    check_eq("t1_idle_busy", 32'(idle), 32'd0);
    step(1);
    check_eq("t1_idle_done", 32'(idle), 32'd1);
    check_eq("t1_opcode_hold", 32'(gpu_opcode), 32'h9);

    // NOPs on an empty FIFO are discarded.
    push(4'h0, 25'h155);
    push(4'h0, 25'h0AA);
    check_eq("nop_count", 32'(fifo_count), 32'd0);
    check_eq("nop_overflow", 32'(overflow), 32'd0);
    count_starts(4, c);
    check_eq("nop_no_start", 32'(c), 32'd0);

    // Fill behind a busy blocker, NOP while full, then overflow.
    gpu_busy = 1'b1;
    push(4'hA, 25'h0AAAAAA);
    step(3);
    check_eq("fill_count0", 32'(fifo_count), 32'd0);
    for (int i = 1; i <= 4; i++) push(4'(i), 25'h1000 + 25'(i));
    check_eq("fill_count4", 32'(fifo_count), 32'd4);
    check_eq("fill_ready0", 32'(cmd_ready), 32'd0);
    check_eq("fill_no_ovf", 32'(overflow), 32'd0);
    push(4'h0, 25'h1);
    check_eq("fill_nop_count", 32'(fifo_count), 32'd4);
    check_eq("fill_nop_ovf", 32'(overflow), 32'd0);
    push(4'h5, 25'h1005);
    check_eq("fill_ovf", 32'(overflow), 32'd1);
    check_eq("fill_ovf_count", 32'(fifo_count), 32'd4);
    gpu_busy = 1'b0;
    for (int i = 1; i <= 4; i++) serve(4'(i), 25'h1000 + 25'(i));
    count_starts(10, c);
    check_eq("fill_no_op5", 32'(c), 32'd0);
    check_eq("fill_drained", 32'(fifo_count), 32'd0);
    check_eq("fill_idle", 32'(idle), 32'd1);

    // Ack timeout with a second command queued behind.
    push(4'hF, 25'h0F0F0F0);
    cmd_valid = 1'b1;
    opcode    = 4'h7;
    params    = 25'h0000777;
    step(1);
    cmd_valid = 1'b0;
    check_eq("to_start", 32'(gpu_start), 32'd1);
    check_eq("to_opcode", 32'(gpu_opcode), 32'hF);
    check_eq("to_count", 32'(fifo_count), 32'd1);
    step(8);
    check_eq("to_not_yet", 32'(timeout), 32'd0);
    step(1);
    check_eq("to_flag", 32'(timeout), 32'd1);
    check_eq("to_no_start", 32'(gpu_start), 32'd0);
    step(1);
    check_eq("to_next_start", 32'(gpu_start), 32'd1);
    check_eq("to_next_opcode", 32'(gpu_opcode), 32'h7);
    gpu_busy = 1'b1;
    step(2);
    gpu_busy = 1'b0;
    step(1);
    check_eq("to_next_idle", 32'(idle), 32'd1);
    check_eq("to_sticky", 32'(timeout), 32'd1);

    // Reset in WAIT_DONE with two commands queued.
    gpu_busy = 1'b1;
    push(4'hB, 25'h0B0);
    push(4'hC, 25'h0C0);
    push(4'hD, 25'h0D0);
    step(1);
    check_eq("mid_count2", 32'(fifo_count), 32'd2);
    n_rst = 1'b0;
    step(1);
    n_rst    = 1'b1;
    gpu_busy = 1'b0;
    check_reset_vals("mid");
    count_starts(10, c);
    check_eq("mid_no_start", 32'(c), 32'd0);

    // Full FIFO with FSM returning to IDLE: push coincides with pop.
    gpu_busy = 1'b1;
    push(4'hE, 25'h0E0);
    step(3);
    push(4'h2, 25'h200);
    push(4'h3, 25'h300);
    push(4'h4, 25'h400);
    push(4'h6, 25'h600);
    check_eq("pp_count4", 32'(fifo_count), 32'd4);
    gpu_busy = 1'b0;
    step(1);
    check_eq("pp_ready0", 32'(cmd_ready), 32'd0);
    check_eq("pp_ovf0", 32'(overflow), 32'd0);
    push(4'h8, 25'h800);
    check_eq("pp_count3", 32'(fifo_count), 32'd3);
    check_eq("pp_ovf1", 32'(overflow), 32'd1);
    check_eq("pp_start", 32'(gpu_start), 32'd1);
    check_eq("pp_opcode", 32'(gpu_opcode), 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
